subtractor_serial_hs: RTL and testbench

//  Multi-cycle subtractor, the inverse of the registered adder datapath:
//  d = a - b - bi, borrow out bo, one CHUNK-bit slice per clock.

---
 rtl/subtractor_serial_hs.sv | 112 +++++++++++
 tb/tb_subtractor_serial_hs.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial_hs.sv
// Sequential subtractor: d = a - b - bi, one CHUNK-bit slice per clock,
// with valid/ready handshakes on operand input and result output.
module subtractor_serial_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW   = CHUNK + 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             bo_q, bo_d;
  logic [CHUNK:0]   diff_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
    end
  end

  // Next-state logic and one slice of subtraction per CALC cycle
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    diff_c   = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
             - {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
             - TW'(borrow_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bi;
          idx_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        d_d[idx_q*CHUNK +: CHUNK] = diff_c[CHUNK-1:0];
        borrow_d                  = diff_c[CHUNK];
        if (idx_q == IDXW'(N - 1)) begin
          bo_d    = diff_c[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_subtractor_serial_hs.sv
// Randomized self-checking bench for subtractor_serial_hs (CHUNK=8 and CHUNK=32 instances).
module tb_subtractor_serial_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, bi;
  logic [31:0] a, b, d;
  logic        bo;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, bi2;
  logic [31:0] a2, b2, d2;
  logic        bo2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  subtractor_serial_hs #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bo(bo)
  );

  subtractor_serial_hs #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bi(bi2), .out_valid(out_valid2), .out_ready(out_ready2),
    .d(d2), .bo(bo2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact unsigned arithmetic on wide integers
  function automatic logic [31:0] ref_d(input logic [31:0] x, input logic [31:0] y, input logic c);
    longint diff;
    diff = longint'(x) - longint'(y) - longint'(c);
    return diff[31:0];
  endfunction

  function automatic logic ref_bo(input logic [31:0] x, input logic [31:0] y, input logic c);
    return (longint'(x) < (longint'(y) + longint'(c)));
  endfunction

  // Present operands for one edge; returns after the accepting edge
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic c);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = x; b = y; bi = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom);
  endtask

  // Count edges after accept until out_valid, then check result
  task automatic wait_result(input logic [31:0] x, input logic [31:0] y, input logic c);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("d", 64'(d), 64'(ref_d(x, y, c)));
    chk("bo", 64'(bo), 64'(ref_bo(x, y, c)));
  endtask

  task automatic finish_op(input int stall, input logic [31:0] x, input logic [31:0] y, input logic c);
    out_ready = 1'b0;
    repeat (stall) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_d", 64'(d), 64'(ref_d(x, y, c)));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
    chk("post_hs_d_held", 64'(d), 64'(ref_d(x, y, c)));
  endtask

  task automatic full_op(input logic [31:0] x, input logic [31:0] y, input logic c, input int stall);
    start_op(x, y, c);
    wait_result(x, y, c);
    finish_op(stall, x, y, c);
  endtask

  // Single-slice instance: result one edge after accept
  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic c, input int stall);
    int lat = 0;
    chk("w32_in_ready", 64'(in_ready2), 64'd1);
    a2 = x; b2 = y; bi2 = c; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    while (!out_valid2 && lat < 10) begin
      tick();
      lat++;
    end
    chk("w32_latency", 64'(lat), 64'd1);
    chk("w32_d", 64'(d2), 64'(ref_d(x, y, c)));
    chk("w32_bo", 64'(bo2), 64'(ref_bo(x, y, c)));
    repeat (stall) tick();
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("w32_post_hs", 64'(out_valid2), 64'd0);
  endtask

  initial begin
    logic [31:0] x, y, nx, ny;
    logic        c, nc;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bi = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_bo", 64'(bo), 64'd0);

    // Directed corner cases
    full_op(32'd5, 32'd3, 1'b0, 0);
    full_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    full_op(32'h0000_0100, 32'h0000_0000, 1'b1, 0);
    full_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);

    // Back-pressure with new operands waiting
    x = 32'hCAFE_0000; y = 32'h0000_BEEF; c = 1'b1;
    nx = 32'h0000_1000; ny = 32'h0000_0001; nc = 1'b0;
    start_op(x, y, c);
    wait_result(x, y, c);
    a = nx; b = ny; bi = nc; in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_d", 64'(d), 64'(ref_d(x, y, c)));
      chk("bp_bo", 64'(bo), 64'(ref_bo(x, y, c)));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted", 64'(in_ready), 64'd0);
    wait_result(nx, ny, nc);
    finish_op(0, nx, ny, nc);

    // Reset during CALC abandons the operation
    start_op(32'h8765_4321, 32'h1111_1111, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_d", 64'(d), 64'd0);
    chk("midrst_bo", 64'(bo), 64'd0);
    begin
      int seen = 0;
      repeat (8) begin
        tick();
        if (out_valid) seen++;
      end
      chk("midrst_no_result", 64'(seen), 64'd0);
    end

    // Random operations with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom);
      if ((i % 8) == 0) y = x;
      full_op(x, y, c, int'($urandom_range(0, 3)));
    end

    // Single-slice configuration
    op32(32'd5, 32'd3, 1'b0, 0);
    op32(32'h0, 32'h1, 1'b0, 0);
    op32(32'h0000_0100, 32'h0, 1'b1, 1);
    for (int i = 0; i < 100; i++) begin
      op32($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
